vote_ctrl: RTL and testbench

Session controller for the `PERSON`-voter majority decision path. It opens a voting window on `start` and latches each voter's first ballot. It closes the window when all voters have voted or a timeout expires, then tallies the ballots. A tie triggers a re-vote, up to `MAX_ROUNDS` rounds in total, before a final result is reported. It sits between the voter-facing request logic and the system consumer of the decision.

---
 rtl/vote_ctrl_pkg.sv | 26 ++
 rtl/vote_ctrl_if.sv | 35 +++
 rtl/vote_tally.sv | 31 +++
 rtl/vote_ctrl.sv | 162 ++++++++++++++++
 tb/tb_vote_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vote_ctrl_pkg.sv
// Shared types and width helpers for the vote_ctrl session controller.
// State encoding is fixed so the debug state can be decoded by external checkers.
package vote_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DECIDE  = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int DEF_PERSON     = 6;
   localparam int DEF_TIMEOUT    = 8;
   localparam int DEF_MAX_ROUNDS = 3;

   // Bits needed to hold a yes-count in 0..person.
   function automatic int cnt_w(input int person);
      return $clog2(person + 1);
   endfunction

   // Bits needed to hold a round number in 0..max_rounds.
   function automatic int rnd_w(input int max_rounds);
      return $clog2(max_rounds + 1);
   endfunction

endpackage

// File: rtl/vote_ctrl_if.sv
// Voter-side and consumer-side signals of vote_ctrl, bundled with the FSM debug state.
// master = whoever drives start/ballots and consumes the decision; slave = vote_ctrl.
interface vote_ctrl_if
   import vote_ctrl_pkg::*;
#(
   parameter int PERSON     = DEF_PERSON,
   parameter int MAX_ROUNDS = DEF_MAX_ROUNDS
);

   // Handshake: there is no back-pressure. start is taken only while the controller
   // is idle (busy=0); vote_valid[i] is a one-cycle strobe qualifying vote_val[i] and is
   // consumed only during a collection window; done is a one-cycle pulse marking
   // result/tie/absent/rounds_used valid, and those hold until the next session decides.
   logic                            start;
   logic [PERSON-1:0]               vote_valid;
   logic [PERSON-1:0]               vote_val;
   logic                            busy;
   logic                            done;
   logic                            result;
   logic                            tie;
   logic                            absent;
   logic [rnd_w(MAX_ROUNDS)-1:0]    rounds_used;
   state_t                          state;

   modport master (
      output start, vote_valid, vote_val,
      input  busy, done, result, tie, absent, rounds_used, state
   );

   modport slave (
      input  start, vote_valid, vote_val,
      output busy, done, result, tie, absent, rounds_used, state
   );

endinterface

// File: rtl/vote_tally.sv
// Combinational tally of latched ballots: strict yes-majority and exact tie,
// both measured against the full electorate so absent voters weigh as "not yes".
module vote_tally
   import vote_ctrl_pkg::*;
#(
   parameter int PERSON = DEF_PERSON
) (
   input  logic [PERSON-1:0] ballot,
   input  logic [PERSON-1:0] got,
   output logic              yes_maj,
   output logic              is_tie
);

   localparam int CW = cnt_w(PERSON);

   logic [CW-1:0] yes;
   logic [CW:0]   twice;

   always_comb begin
      yes = '0;
      for (int i = 0; i < PERSON; i++) begin
         yes = yes + CW'(ballot[i] & got[i]);
      end
   end

   // Comparing 2*yes with PERSON avoids any rounding for odd electorates.
   assign twice   = {yes, 1'b0};
   assign yes_maj = (twice > (CW+1)'(PERSON));
   assign is_tie  = (twice == (CW+1)'(PERSON));

endmodule

// File: rtl/vote_ctrl.sv
// Majority-vote session controller: collection window, tally, bounded re-votes on tie,
// and a registered final decision that holds until the next session decides.
module vote_ctrl
   import vote_ctrl_pkg::*;
#(
   parameter int PERSON     = DEF_PERSON,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int MAX_ROUNDS = DEF_MAX_ROUNDS
) (
   input  logic       clk,
   input  logic       reset,
   vote_ctrl_if.slave bus
);

   localparam int RW = rnd_w(MAX_ROUNDS);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t            state;
   state_t            state_nxt;
   logic [PERSON-1:0] ballot;
   logic [PERSON-1:0] got;
   logic [PERSON-1:0] fresh;
   logic [PERSON-1:0] got_nxt;
   logic [TW-1:0]     timer;
   logic [RW-1:0]     round;

   logic              yes_maj;
   logic              is_tie;
   logic              all_in;
   logic              timeout_hit;
   logic              last_round;
   logic              revote;
   logic              close_win;

   logic              busy;
   logic              done;
   logic              result_q;
   logic              tie_q;
   logic              absent_q;
   logic [RW-1:0]     rounds_used_q;

   vote_tally #(.PERSON(PERSON)) u_tally (
      .ballot  (ballot),
      .got     (got),
      .yes_maj (yes_maj),
      .is_tie  (is_tie)
   );

   // Only a voter's first strobe in a round is kept; repeats are masked off here.
   assign fresh       = bus.vote_valid & ~got;
   assign got_nxt     = got | bus.vote_valid;
   assign all_in      = &got_nxt;
   assign timeout_hit = (timer == TW'(TIMEOUT - 1));
   assign close_win   = all_in | timeout_hit;
   assign last_round  = (round == RW'(MAX_ROUNDS));
   assign revote      = is_tie & ~last_round;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = COLLECT;
         COLLECT: if (close_win) state_nxt = DECIDE;
         DECIDE:  state_nxt = revote ? COLLECT : DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         IDLE:    busy = 1'b0;
         COLLECT: busy = 1'b1;
         DECIDE:  busy = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ballot <= '0;
         got    <= '0;
         timer  <= '0;
         round  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  ballot <= '0;
                  got    <= '0;
                  timer  <= '0;
                  round  <= RW'(1);
               end
            end
            COLLECT: begin
               ballot <= ballot | (bus.vote_val & fresh);
               got    <= got_nxt;
               if (!close_win) timer <= timer + TW'(1);
            end
            DECIDE: begin
               if (revote) begin
                  ballot <= '0;
                  got    <= '0;
                  timer  <= '0;
                  round  <= round + RW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Decision outputs move only on the edge that enters DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q      <= 1'b0;
         tie_q         <= 1'b0;
         absent_q      <= 1'b0;
         rounds_used_q <= '0;
      end else if (state == DECIDE && !revote) begin
         result_q      <= yes_maj;
         tie_q         <= is_tie;
         absent_q      <= ~&got;
         rounds_used_q <= round;
      end
   end

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.result      = result_q;
   assign bus.tie         = tie_q;
   assign bus.absent      = absent_q;
   assign bus.rounds_used = rounds_used_q;
   assign bus.state       = state;

   a_done_one_cycle: assert property (@(posedge clk) disable iff (reset)
      done |=> !done);

   a_round_in_range: assert property (@(posedge clk) disable iff (reset)
      (state != IDLE) |-> (round >= RW'(1) && round <= RW'(MAX_ROUNDS)));

   a_timer_bounded: assert property (@(posedge clk) disable iff (reset)
      (state == COLLECT) |-> (timer <= TW'(TIMEOUT - 1)));

   a_result_not_tie: assert property (@(posedge clk) disable iff (reset)
      done |-> !(result_q && tie_q));

endmodule

// File: tb/tb_vote_ctrl.sv
// Self-checking bench for vote_ctrl with PERSON=6, TIMEOUT=8, MAX_ROUNDS=3.
// Expected decisions are queued when a session is launched and popped on done.
module tb_vote_ctrl;
   import vote_ctrl_pkg::*;

   localparam int PERSON     = 6;
   localparam int TIMEOUT    = 8;
   localparam int MAX_ROUNDS = 3;
   localparam int W          = 5;

   logic clk = 1'b0;
   logic reset;

   vote_ctrl_if #(.PERSON(PERSON), .MAX_ROUNDS(MAX_ROUNDS)) bus ();

   vote_ctrl #(.PERSON(PERSON), .TIMEOUT(TIMEOUT), .MAX_ROUNDS(MAX_ROUNDS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.start      = 1'b0;
      bus.vote_valid = '0;
      bus.vote_val   = '0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   // Drive one ballot pattern on the first COLLECT cycle and count COLLECT cycles.
   task automatic collect_round(input logic [PERSON-1:0] v, input logic [PERSON-1:0] b,
                                output int ncyc);
      ncyc = 0;
      bus.vote_valid = v;
      bus.vote_val   = b;
      while (bus.state == COLLECT && ncyc < 20) begin
         step();
         bus.vote_valid = '0;
         bus.vote_val   = '0;
         ncyc++;
      end
      bus.vote_valid = '0;
      bus.vote_val   = '0;
   endtask

   task automatic wait_done(input int max, output int ncyc);
      ncyc = 0;
      while (!bus.done && ncyc < max) begin
         step();
         ncyc++;
      end
   endtask

   function automatic logic [W-1:0] model_single(input logic [PERSON-1:0] val);
      int yes;
      yes = $countones(val);
      if (2 * yes > PERSON)      return {1'b1, 1'b0, 1'b0, 2'd1};
      else if (2 * yes < PERSON) return {1'b0, 1'b0, 1'b0, 2'd1};
      else                       return {1'b0, 1'b1, 1'b0, 2'(MAX_ROUNDS)};
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [W-1:0] obs;
      drive_idle();
      reset = 1'b1;
      #3;
      obs = {bus.result, bus.tie, bus.absent, bus.rounds_used};
      n_vec++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctl: busy=%b done=%b, required 0 0", bus.busy, bus.done);
      end
      n_vec++;
      if (obs !== '0) begin
         n_err++;
         $display("FAIL reset_out: got %b, required %b", obs, 5'b0);
      end
      n_vec++;
      if (bus.state !== IDLE) begin
         n_err++;
         $display("FAIL reset_state: got %0d, required %0d", bus.state, IDLE);
      end
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_fast();
      int n, w, lat;
      logic [W-1:0] obs, exp_v;
      exp_q.push_back({1'b1, 1'b0, 1'b0, 2'd1});
      pulse_start();
      lat = 1;
      n_vec++;
      if (bus.busy !== 1'b1 || bus.state !== COLLECT) begin
         n_err++;
         $display("FAIL fast_busy: busy=%b state=%0d, required 1 %0d", bus.busy, bus.state, COLLECT);
      end
      collect_round(6'h3F, 6'h3F, n);
      lat += n;
      n_vec++;
      if (n !== 1) begin
         n_err++;
         $display("FAIL fast_collect_len: got %0d, required 1", n);
      end
      wait_done(5, w);
      lat += w;
      n_vec++;
      if (bus.done !== 1'b1 || lat !== 3) begin
         n_err++;
         $display("FAIL fast_latency: done=%b latency=%0d, required 1 3", bus.done, lat);
      end
      obs = {bus.result, bus.tie, bus.absent, bus.rounds_used};
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL fast_result: got %b, required %b", obs, exp_v);
      end
      step();
      n_vec++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_err++;
         $display("FAIL fast_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_timeout(input logic [W-1:0] prev_v);
      int n, w;
      logic [W-1:0] obs, exp_v;
      exp_q.push_back({1'b1, 1'b0, 1'b1, 2'd2});
      pulse_start();
      collect_round(6'h07, 6'h07, n);
      n_vec++;
      if (n !== TIMEOUT) begin
         n_err++;
         $display("FAIL timeout_len_r1: got %0d, required %0d", n, TIMEOUT);
      end
      step();
      obs = {bus.result, bus.tie, bus.absent, bus.rounds_used};
      n_vec++;
      if (bus.state !== COLLECT || obs !== prev_v) begin
         n_err++;
         $display("FAIL timeout_revote: state=%0d out=%b, required %0d %b", bus.state, obs, COLLECT, prev_v);
      end
      collect_round(6'h0F, 6'h0F, n);
      n_vec++;
      if (n !== TIMEOUT) begin
         n_err++;
         $display("FAIL timeout_len_r2: got %0d, required %0d", n, TIMEOUT);
      end
      wait_done(5, w);
      n_vec++;
      if (bus.done !== 1'b1 || w !== 1) begin
         n_err++;
         $display("FAIL timeout_done: done=%b wait=%0d, required 1 1", bus.done, w);
      end
      obs = {bus.result, bus.tie, bus.absent, bus.rounds_used};
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL timeout_result: got %b, required %b", obs, exp_v);
      end
      step();
   endtask

   task automatic test_tie_exhaust();
      int n, w;
      logic [W-1:0] obs, exp_v;
      exp_q.push_back({1'b0, 1'b1, 1'b0, 2'd3});
      pulse_start();
      for (int r = 0; r < MAX_ROUNDS; r++) begin
         collect_round(6'h3F, 6'h07, n);
         n_vec++;
         if (n !== 1) begin
            n_err++;
            $display("FAIL tie_round_len: round=%0d got %0d, required 1", r + 1, n);
         end
         if (r < MAX_ROUNDS - 1) step();
      end
      wait_done(5, w);
      obs = {bus.result, bus.tie, bus.absent, bus.rounds_used};
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (bus.done !== 1'b1 || obs !== exp_v) begin
         n_err++;
         $display("FAIL tie_result: done=%b got %b, required 1 %b", bus.done, obs, exp_v);
      end
      step();
   endtask

   task automatic test_duplicate_late();
      int n, w;
      logic [W-1:0] obs, exp_v;
      exp_q.push_back({1'b0, 1'b0, 1'b0, 2'd1});
      pulse_start();
      bus.vote_valid = 6'h01;
      bus.vote_val   = 6'h01;
      step();
      collect_round(6'h3F, 6'h00, n);
      n_vec++;
      if (n !== 1) begin
         n_err++;
         $display("FAIL dup_collect_len: got %0d, required 1", n);
      end
      bus.vote_valid = 6'h3F;
      bus.vote_val   = 6'h3F;
      wait_done(5, w);
      drive_idle();
      obs = {bus.result, bus.tie, bus.absent, bus.rounds_used};
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (bus.done !== 1'b1 || obs !== exp_v) begin
         n_err++;
         $display("FAIL dup_result: done=%b got %b, required 1 %b", bus.done, obs, exp_v);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int n, w;
      logic [W-1:0] obs, exp_v;
      pulse_start();
      bus.vote_valid = 6'h07;
      bus.vote_val   = 6'h07;
      step();
      drive_idle();
      step();
      #2;
      reset = 1'b1;
      #1;
      obs = {bus.result, bus.tie, bus.absent, bus.rounds_used};
      n_vec++;
      if (bus.busy !== 1'b0 || bus.state !== IDLE || bus.done !== 1'b0 || obs !== '0) begin
         n_err++;
         $display("FAIL midreset: busy=%b state=%0d done=%b out=%b, required 0 0 0 00000",
                  bus.busy, bus.state, bus.done, obs);
      end
      step();
      reset = 1'b0;
      step();
      exp_q.push_back({1'b0, 1'b0, 1'b1, 2'd1});
      pulse_start();
      collect_round(6'h30, 6'h30, n);
      n_vec++;
      if (n !== TIMEOUT) begin
         n_err++;
         $display("FAIL midreset_len: got %0d, required %0d", n, TIMEOUT);
      end
      wait_done(5, w);
      obs = {bus.result, bus.tie, bus.absent, bus.rounds_used};
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (bus.done !== 1'b1 || obs !== exp_v) begin
         n_err++;
         $display("FAIL midreset_clean: done=%b got %b, required 1 %b", bus.done, obs, exp_v);
      end
      step();
   endtask

   task automatic test_start_held();
      int dones;
      logic was_done;
      logic [W-1:0] obs, exp_v;
      dones    = 0;
      was_done = 1'b0;
      for (int k = 0; k < 5; k++) exp_q.push_back({1'b0, 1'b0, 1'b0, 2'd1});
      bus.start      = 1'b1;
      bus.vote_valid = 6'h3F;
      bus.vote_val   = 6'h00;
      for (int i = 0; i < 20; i++) begin
         step();
         if (was_done) begin
            n_vec++;
            if (bus.busy !== 1'b0) begin
               n_err++;
               $display("FAIL held_start_in_done: busy=%b, required 0", bus.busy);
            end
         end
         if (bus.done) begin
            dones++;
            obs = {bus.result, bus.tie, bus.absent, bus.rounds_used};
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_vec++;
            if (obs !== exp_v) begin
               n_err++;
               $display("FAIL held_result: got %b, required %b", obs, exp_v);
            end
         end
         was_done = bus.done;
      end
      drive_idle();
      n_vec++;
      if (dones !== 5) begin
         n_err++;
         $display("FAIL held_done_count: got %0d, required 5", dones);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int n, w;
      logic [PERSON-1:0] val;
      logic [W-1:0] obs, exp_v;
      for (int k = 0; k < 6; k++) begin
         val = PERSON'($urandom_range(0, 63));
         if (k == 0) val = 6'h15;
         exp_q.push_back(model_single(val));
         pulse_start();
         for (int r = 0; r < MAX_ROUNDS; r++) begin
            collect_round(6'h3F, val, n);
            step();
            if (bus.done) break;
         end
         obs = {bus.result, bus.tie, bus.absent, bus.rounds_used};
         exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         n_vec++;
         if (bus.done !== 1'b1 || obs !== exp_v) begin
            n_err++;
            $display("FAIL b2b_result: val=%h done=%b got %b, required 1 %b", val, bus.done, obs, exp_v);
         end
         bus.start = 1'b1;
         step();
         bus.start = 1'b0;
         n_vec++;
         if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_start_in_done: busy=%b, required 0", bus.busy);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_fast();
      test_timeout({1'b1, 1'b0, 1'b0, 2'd1});
      test_tie_exhaust();
      test_duplicate_late();
      test_reset_mid();
      test_start_held();
      test_back_to_back();
      n_vec++;
      if (exp_q.size() !== 0) begin
         n_err++;
         $display("FAIL queue_drain: %0d left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
